mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register and write-back selector for the 64-bit LEGv8 pipeline.
- Sits directly downstream of the data-memory stage. Consumes the EX/MEM bundle (PR3) and the memory read data.
- Drives register-file write port and stalls upstream while a data-memory access is outstanding (variable-latency memory, bounded by a timeout).

Parameters:
- DATA_W, 64, datapath width.
- REG_ADDR_W, 5, register-file address width.
- PR3_W, 500, width of EX/MEM bundle.
- MEM_TIMEOUT, 15, max wait cycles for mem_ready before abort.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pr3  in  PR3_W  EX/MEM bundle: ALU result [424:361], MemRead [100], MemWrite [101], RegWrite [102], MemtoReg [103], Rd [108:104].
- pr3_valid  in  1  bundle holds a real instruction (0 = bubble).
- read_data  in  DATA_W  load data from memory stage.
- mem_ready  in  1  memory access complete / read_data valid this cycle.
- stall  out  1  upstream must hold pr3 this cycle.
- wb_en  out  1  register-file write enable.
- wb_addr  out  REG_ADDR_W  destination register.
- wb_data  out  DATA_W  write-back value.
- mem_timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n=0): state RUN, wait counter 0, PR4 cleared.
  - wb_en=0, wb_addr=0, wb_data=0, mem_timeout_err=0, stall=0.
- Access = pr3_valid & (MemRead | MemWrite).
- FSM RUN:
  - Non-access or bubble: capture into PR4 every cycle.
  - Access with mem_ready=1: capture same cycle, no stall.
  - Access with mem_ready=0: stall=1 (combinational), go WAIT, counter=1, PR4 loads a bubble (wb_en=0 next cycle).
- FSM WAIT:
  - stall = ~mem_ready.
  - mem_ready=1: capture pr3 + read_data, counter=0, go RUN.
  - Otherwise counter++. When counter reaches MEM_TIMEOUT with mem_ready=0:
    - Commit bubble (wb_en=0).
    - Set mem_timeout_err (sticky until reset).
    - stall=0 that cycle, go RUN.
- Capture: PR4 latches valid, RegWrite, MemtoReg, Rd, ALU result, and read_data (sampled only when MemRead).
- Outputs are registered from PR4; latency is one clock from accept to wb_*.
  - wb_data = MemtoReg ? read_data : ALU result.
  - wb_en = valid & RegWrite & (Rd != 31); X31 (XZR) is never written.
  - wb_addr = Rd, wb_data = selected value, even when wb_en=0.
- Store (MemWrite, RegWrite=0): waits on mem_ready like a load, then commits wb_en=0.
- MemRead & MemWrite both set: treated as load for write-back; wait rule unchanged.
- Reset mid-WAIT: aborts immediately to RUN, no commit, error cleared.
- pr3 changing while stall=1 is an upstream protocol violation; the block samples only on capture.

Optional Feature:
- Macro WB_PERF_EN.
- Defined: adds outputs retired_count[31:0] and stall_cycles[31:0].
  - retired_count increments on each commit with wb_en=1.
  - stall_cycles increments on each cycle with stall=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD: pr3 valid, RegWrite=1, MemtoReg=0, Rd=9, ALU=64'h0000_0000_0000_0030, no access -> next cycle wb_en=1, wb_addr=9, wb_data=64'h30, stall never asserted.
- LDUR zero-wait: MemRead=1, MemtoReg=1, Rd=3, mem_ready=1, read_data=64'h4444_4444_4444_4444 -> next cycle wb_en=1, wb_addr=3, wb_data=64'h4444444444444444.
- LDUR 3-cycle wait: mem_ready low 3 cycles then high with read_data=64'h8888888888888888 -> stall high exactly 3 cycles, one commit, wb_data=64'h8888888888888888.
- Timeout: MemRead, mem_ready held 0 -> stall high MEM_TIMEOUT-1 cycles, then bubble commit (wb_en=0), mem_timeout_err=1 and stays 1 until reset_n pulse.
- XZR and store: RegWrite=1, Rd=31 -> wb_en=0; STUR (MemWrite=1, RegWrite=0) with mem_ready=1 -> wb_en=0, no stall.
- Async reset mid-WAIT: drop reset_n between clock edges -> wb_en, stall, mem_timeout_err go 0 immediately; after release, next ADD commits normally.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register + write-back select; 1 clk accept->wb_*; stalls upstream while a data access waits on mem_ready, aborting after MEM_TIMEOUT.
// Optional macro WB_PERF_EN adds retired_count / stall_cycles performance counters.
module mem_wb_writeback #(
    parameter int DATA_W      = 64,
    parameter int REG_ADDR_W  = 5,
    parameter int PR3_W       = 500,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [PR3_W-1:0]      pr3,
    input  logic                  pr3_valid,
    input  logic [DATA_W-1:0]     read_data,
    input  logic                  mem_ready,
    output logic                  stall,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_timeout_err
`ifdef WB_PERF_EN
    ,
    output logic [31:0]           retired_count,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int MEMRD  = 100;
    localparam int MEMWR  = 101;
    localparam int REGWR  = 102;
    localparam int M2R    = 103;
    localparam int RD_LO  = 104;
    localparam int ALU_LO = 361;
    localparam int CNT_W  = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, regwr_q, m2r_q, err_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     alu_q, rdata_q;

    logic access, capture, bubble, timeout, stall_c;
    logic unused_pr3_bits;

    assign access = pr3_valid & (pr3[MEMRD] | pr3[MEMWR]);
    assign unused_pr3_bits = ^{pr3[PR3_W-1:ALU_LO+DATA_W], pr3[ALU_LO-1:RD_LO+REG_ADDR_W],
                               pr3[MEMRD-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        bubble  = 1'b0;
        timeout = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (access && !mem_ready) begin
                    stall_c = 1'b1;
                    bubble  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_WAIT;
                end else begin
                    capture = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    // Final wait cycle: release upstream and drop the access.
                    timeout = 1'b1;
                    bubble  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    stall_c = 1'b1;
                    bubble  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
            m2r_q   <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | timeout;
            if (capture) begin
                valid_q <= pr3_valid;
                regwr_q <= pr3[REGWR];
                m2r_q   <= pr3[M2R];
                rd_q    <= pr3[RD_LO +: REG_ADDR_W];
                alu_q   <= pr3[ALU_LO +: DATA_W];
                rdata_q <= pr3[MEMRD] ? read_data : '0;
            end else if (bubble) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Gated by reset so upstream is released the instant reset asserts.
    assign stall           = stall_c & reset_n;
    assign wb_en           = valid_q & regwr_q & (rd_q != {REG_ADDR_W{1'b1}});
    assign wb_addr         = rd_q;
    assign wb_data         = m2r_q ? rdata_q : alu_q;
    assign mem_timeout_err = err_q;

`ifdef WB_PERF_EN
    logic commit_en;
    assign commit_en = capture & pr3_valid & pr3[REGWR] &
                       (pr3[RD_LO +: REG_ADDR_W] != {REG_ADDR_W{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_count <= '0;
            stall_cycles  <= '0;
        end else begin
            if (commit_en) retired_count <= retired_count + 32'd1;
            if (stall)     stall_cycles  <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized self-checking bench for mem_wb_writeback against a transaction-level model.
module tb_mem_wb_writeback;
    localparam int DATA_W = 64;
    localparam int RAW    = 5;
    localparam int PW     = 500;
    localparam int MT     = 15;

    logic            clock;
    logic            reset_n;
    logic [PW-1:0]   pr3;
    logic            pr3_valid;
    logic [63:0]     read_data;
    logic            mem_ready;
    logic            stall;
    logic            wb_en;
    logic [RAW-1:0]  wb_addr;
    logic [63:0]     wb_data;
    logic            mem_timeout_err;

    int checks = 0;
    int errors = 0;
    logic err_m = 1'b0;

    mem_wb_writeback #(.DATA_W(DATA_W), .REG_ADDR_W(RAW), .PR3_W(PW), .MEM_TIMEOUT(MT)) dut (
        .clock(clock), .reset_n(reset_n), .pr3(pr3), .pr3_valid(pr3_valid),
        .read_data(read_data), .mem_ready(mem_ready), .stall(stall), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .mem_timeout_err(mem_timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] mk_pr3(input logic mr, input logic mw, input logic rw,
                                             input logic m2r, input logic [4:0] rd,
                                             input logic [63:0] alu);
        logic [511:0] big;
        logic [PW-1:0] p;
        for (int i = 0; i < 16; i++) big[i*32 +: 32] = $urandom;
        p = big[PW-1:0];
        p[424:361] = alu;
        p[100] = mr;
        p[101] = mw;
        p[102] = rw;
        p[103] = m2r;
        p[108:104] = rd;
        return p;
    endfunction

    // One instruction held until accepted; mem_ready rises after w cycles.
    task automatic do_instr(input string nm, input logic mr, input logic mw, input logic rw,
                            input logic m2r, input logic [4:0] rd, input logic [63:0] alu,
                            input logic [63:0] rdat, input int w);
        int cyc = 0;
        int stalls = 0;
        bit done = 0;
        bit exp_commit;
        int exp_stalls;
        logic exp_en;
        logic [63:0] exp_data;
        exp_commit = (w < MT);
        exp_stalls = exp_commit ? w : MT - 1;
        exp_en     = exp_commit && rw && (rd != 5'd31);
        exp_data   = m2r ? (mr ? rdat : 64'd0) : alu;
        if (!exp_commit && (mr || mw)) err_m = 1'b1;
        pr3 = mk_pr3(mr, mw, rw, m2r, rd, alu);
        pr3_valid = 1'b1;
        while (!done && cyc < 40) begin
            mem_ready = (cyc >= w);
            read_data = mem_ready ? rdat : {$urandom, $urandom};
            @(negedge clock);
            if (stall === 1'b1) stalls++;
            else done = 1;
            if (cyc >= 1) begin
                checks++;
                if (wb_en !== 1'b0) begin
                    errors++;
                    $display("FAIL %s wait_bubble: wb_en=%b required 0 (cycle %0d)", nm, wb_en, cyc);
                end
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        pr3_valid = 1'b0;
        mem_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s accept_bound: stall still high after %0d cycles, required release", nm, cyc);
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d required %0d", nm, stalls, exp_stalls);
        end
        checks++;
        if (wb_en !== exp_en) begin
            errors++;
            $display("FAIL %s wb_en: got %b required %b", nm, wb_en, exp_en);
        end
        if (exp_commit) begin
            checks++;
            if (wb_addr !== rd) begin
                errors++;
                $display("FAIL %s wb_addr: got %0d required %0d", nm, wb_addr, rd);
            end
            checks++;
            if (wb_data !== exp_data) begin
                errors++;
                $display("FAIL %s wb_data: got %h required %h", nm, wb_data, exp_data);
            end
        end
        checks++;
        if (mem_timeout_err !== err_m) begin
            errors++;
            $display("FAIL %s timeout_err: got %b required %b", nm, mem_timeout_err, err_m);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pr3 = mk_pr3(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 64'd5);
        pr3_valid = 1'b1;
        mem_ready = 1'b0;
        read_data = 64'd0;
        #3;
        checks++;
        if ({stall, wb_en, mem_timeout_err} !== 3'b000 || wb_addr !== 5'd0 || wb_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: stall=%b wb_en=%b err=%b addr=%0d data=%h required all 0",
                     stall, wb_en, mem_timeout_err, wb_addr, wb_data);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        pr3_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: wb_en=%b required 0", wb_en);
        end
    endtask

    task automatic test_directed();
        do_instr("add",      1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 64'h30, 64'h0, 0);
        do_instr("ldur0",    1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 64'h1000, 64'h4444_4444_4444_4444, 0);
        do_instr("ldur3",    1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 64'h2000, 64'h8888_8888_8888_8888, 3);
        do_instr("xzr",      1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 64'hABCD, 64'h0, 0);
        do_instr("stur",     1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 64'h40, 64'h0, 0);
        do_instr("stur_w2",  1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 64'h48, 64'h0, 2);
        do_instr("rdwr",     1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 64'h50, 64'h1234_5678_9ABC_DEF0, 1);
        do_instr("ld_max",   1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 64'h60, 64'hCAFE_F00D_0000_0001, MT - 1);
    endtask

    task automatic test_bubble();
        pr3 = mk_pr3(1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 64'h77);
        pr3_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL bubble_stall: stall=%b required 0", stall);
        end
        @(posedge clock);
        #1;
        checks++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL bubble_wb_en: wb_en=%b required 0", wb_en);
        end
    endtask

    task automatic test_timeout();
        do_instr("timeout", 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'h90, 64'hDEAD, MT + 5);
        do_instr("sticky",  1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 64'h91, 64'h0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 3);
            logic mr = (kind == 1) || (kind == 3);
            logic mw = (kind == 2) || (kind == 3);
            logic rw = (kind == 2) ? 1'b0 : 1'($urandom);
            logic [4:0] rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            int w = (mr || mw) ? (($urandom_range(0, 9) == 0) ? MT + $urandom_range(0, 2)
                                                              : $urandom_range(0, 5)) : 0;
            do_instr("rand", mr, mw, rw, mr, rd, {$urandom, $urandom}, {$urandom, $urandom}, w);
        end
    endtask

    task automatic test_async_reset();
        pr3 = mk_pr3(1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 64'h99);
        pr3_valid = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_stall: stall=%b required 1", stall);
        end
        #2;
        reset_n = 1'b0;
        err_m = 1'b0;
        #1;
        checks++;
        if ({wb_en, stall, mem_timeout_err} !== 3'b000 || wb_addr !== 5'd0) begin
            errors++;
            $display("FAIL arst_mid_wait: wb_en=%b stall=%b err=%b addr=%0d required 0",
                     wb_en, stall, mem_timeout_err, wb_addr);
        end
        pr3_valid = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        do_instr("arst_add", 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 64'h30, 64'h0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bubble();
        test_timeout();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
